front_panel_controller: RTL and testbench



---
 rtl/front_panel_pkg.sv | 45 ++++
 rtl/fp_edge_detect.sv | 18 +
 rtl/front_panel_controller.sv | 130 +++++++++++++
 tb/tb_front_panel_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/front_panel_pkg.sv
// Shared state encoding, width defaults and button priority for the front-panel sequencer.
package front_panel_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEM_REQ   = 2'd1,
    ST_RUN       = 2'd2,
    ST_STEP_WAIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_EXAMINE,
    CMD_EXAMINE_NEXT,
    CMD_DEPOSIT,
    CMD_DEPOSIT_NEXT,
    CMD_STEP,
    CMD_RUN
  } cmd_t;

  // Bit positions in the packed button vector; a higher index wins.
  localparam int BTN_EXAMINE      = 0;
  localparam int BTN_EXAMINE_NEXT = 1;
  localparam int BTN_DEPOSIT      = 2;
  localparam int BTN_DEPOSIT_NEXT = 3;
  localparam int BTN_STEP         = 4;
  localparam int BTN_RUN          = 5;
  localparam int BTN_COUNT        = 6;

  function automatic cmd_t pick_cmd(input logic [BTN_COUNT-1:0] btns);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (btns[BTN_EXAMINE])      cmd = CMD_EXAMINE;
    if (btns[BTN_EXAMINE_NEXT]) cmd = CMD_EXAMINE_NEXT;
    if (btns[BTN_DEPOSIT])      cmd = CMD_DEPOSIT;
    if (btns[BTN_DEPOSIT_NEXT]) cmd = CMD_DEPOSIT_NEXT;
    if (btns[BTN_STEP])         cmd = CMD_STEP;
    if (btns[BTN_RUN])          cmd = CMD_RUN;
    return cmd;
  endfunction

endpackage

// File: rtl/fp_edge_detect.sv
// Rising-edge detector: remembers last cycle's level and flags a 0->1 transition.
module fp_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_old;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_old <= 1'b0;
    else     sig_old <= sig;
  end

  assign rise = sig & ~sig_old;

endmodule

// File: rtl/front_panel_controller.sv
// Front-panel sequencer: examine/deposit over a req/ack memory port, or run/stop/step
// gating of the divided CPU clock. Owns the memory bus whenever the CPU is stopped.
module front_panel_controller
  import front_panel_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              qzt_clk,
  input  logic              reset,
  input  logic              btn_examine,
  input  logic              btn_examine_next,
  input  logic              btn_deposit,
  input  logic              btn_deposit_next,
  input  logic              btn_run,
  input  logic              btn_stop,
  input  logic              btn_step,
  input  logic [ADDR_W-1:0] addr_sw,
  input  logic [DATA_W-1:0] data_sw,
  input  logic              cpu_clk_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_clk_en,
  output logic              cpu_running,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] data_led
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        wait_cnt_reg;
  logic              cpu_rise;
  cmd_t              cmd;
  logic              cmd_write;

  fp_edge_detect u_cpu_edge (
    .clk  (qzt_clk),
    .rst  (reset),
    .sig  (cpu_clk_in),
    .rise (cpu_rise)
  );

  assign cmd = pick_cmd({btn_run, btn_step, btn_deposit_next, btn_deposit,
                         btn_examine_next, btn_examine});
  assign cmd_write = (cmd == CMD_DEPOSIT) || (cmd == CMD_DEPOSIT_NEXT);
  assign addr_next = addr_reg + ADDR_W'(1);
  assign mem_addr  = addr_reg;
  assign busy      = (state_reg != ST_IDLE);

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      wait_cnt_reg <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      data_led     <= '0;
      cpu_clk_en   <= 1'b0;
      cpu_running  <= 1'b0;
      err          <= 1'b0;
    end else begin
      cpu_clk_en <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          case (cmd)
            CMD_RUN: begin
              state_reg   <= ST_RUN;
              cpu_running <= 1'b1;
            end
            CMD_STEP: state_reg <= ST_STEP_WAIT;
            CMD_EXAMINE, CMD_EXAMINE_NEXT, CMD_DEPOSIT, CMD_DEPOSIT_NEXT: begin
              state_reg    <= ST_MEM_REQ;
              mem_req      <= 1'b1;
              mem_we       <= cmd_write;
              err          <= 1'b0;
              wait_cnt_reg <= '0;
              if (cmd_write) mem_wdata <= data_sw;
              // Plain deposit writes at the current address; only examine reloads it.
              if (cmd == CMD_EXAMINE)
                addr_reg <= addr_sw;
              else if (cmd == CMD_EXAMINE_NEXT || cmd == CMD_DEPOSIT_NEXT)
                addr_reg <= addr_next;
            end
            default: ;
          endcase
        end
        ST_MEM_REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            data_led  <= mem_we ? mem_wdata : mem_rdata;
            state_reg <= ST_IDLE;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        ST_RUN: begin
          // A stop in the same cycle as a CPU clock edge swallows that tick.
          if (btn_stop) begin
            state_reg   <= ST_IDLE;
            cpu_running <= 1'b0;
          end else begin
            cpu_clk_en <= cpu_rise;
          end
        end
        ST_STEP_WAIT: begin
          if (cpu_rise) begin
            cpu_clk_en <= 1'b1;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_front_panel_controller.sv
// Bench for front_panel_controller: directed and randomized button sequences checked
// against a transaction-level model of address, data, error flag and a memory image.
module tb_front_panel_controller;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 255;

  localparam logic [6:0] P_EX   = 7'h01;
  localparam logic [6:0] P_EXN  = 7'h02;
  localparam logic [6:0] P_DEP  = 7'h04;
  localparam logic [6:0] P_DEPN = 7'h08;
  localparam logic [6:0] P_STEP = 7'h10;
  localparam logic [6:0] P_RUN  = 7'h20;
  localparam logic [6:0] P_STOP = 7'h40;

  logic              qzt_clk = 1'b0;
  logic              reset = 1'b1;
  logic [6:0]        btn = '0;
  logic [ADDR_W-1:0] addr_sw = '0;
  logic [DATA_W-1:0] data_sw = '0;
  logic              cpu_clk_in = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              mem_req, mem_we, cpu_clk_en, cpu_running, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, data_led;

  front_panel_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .qzt_clk          (qzt_clk),
    .reset            (reset),
    .btn_examine      (btn[0]),
    .btn_examine_next (btn[1]),
    .btn_deposit      (btn[2]),
    .btn_deposit_next (btn[3]),
    .btn_step         (btn[4]),
    .btn_run          (btn[5]),
    .btn_stop         (btn[6]),
    .addr_sw          (addr_sw),
    .data_sw          (data_sw),
    .cpu_clk_in       (cpu_clk_in),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .cpu_clk_en       (cpu_clk_en),
    .cpu_running      (cpu_running),
    .busy             (busy),
    .err              (err),
    .data_led         (data_led)
  );

  always #5 qzt_clk = ~qzt_clk;

  int total = 0;
  int bad = 0;

  // Reference state
  logic [15:0] m_addr  = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_led   = '0;
  logic [7:0]  mem [logic [15:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Index of the winning button (run > step > deposit_next > deposit > examine_next > examine).
  function automatic int top_cmd(input logic [6:0] b);
    int order [6] = '{5, 4, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++) if (b[order[i]]) return order[i];
    return -1;
  endfunction

  // Called right after a falling edge; holds the buttons for one rising edge.
  task automatic press(input logic [6:0] b);
    btn = b;
    @(negedge qzt_clk);
    btn = '0;
  endtask

  task automatic mem_txn(input logic [6:0] b, input logic [15:0] asw, input logic [7:0] dsw,
                         input int lat);
    int w;
    logic is_wr;
    logic [15:0] ea;
    logic [7:0] exp_led;
    w = top_cmd(b);
    is_wr = (w == 2 || w == 3);
    ea = (w == 0) ? asw : ((w == 1 || w == 3) ? m_addr + 16'd1 : m_addr);
    addr_sw = asw;
    data_sw = dsw;
    press(b);
    m_addr = ea;
    if (is_wr) m_wdata = dsw;
    data_sw = ~dsw;
    addr_sw = ~asw;
    check("req_rise", 32'(mem_req), 1);
    check("req_addr", 32'(mem_addr), 32'(ea));
    check("req_we", 32'(mem_we), 32'(is_wr));
    check("req_busy", 32'(busy), 1);
    for (int i = 0; i < lat; i++) begin
      @(negedge qzt_clk);
      check("req_hold", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, is_wr, ea}));
    end
    exp_led = is_wr ? dsw : mem_rd(ea);
    mem_ack = 1'b1;
    mem_rdata = is_wr ? 8'($urandom) : mem_rd(ea);
    @(negedge qzt_clk);
    mem_ack = 1'b0;
    mem_rdata = 8'($urandom);
    if (is_wr) mem[ea] = dsw;
    m_led = exp_led;
    check("ack_req_low", 32'(mem_req), 0);
    check("ack_idle", 32'(busy), 0);
    check("ack_led", 32'(data_led), 32'(m_led));
    check("ack_err", 32'(err), 0);
    check("ack_wdata", 32'(mem_wdata), 32'(m_wdata));
    $display("txn mem cmd=%0d addr=%h we=%0d led=%h lat=%0d", w, ea, is_wr, data_led, lat);
  endtask

  task automatic timeout_txn(input logic [15:0] asw);
    int hi;
    addr_sw = asw;
    press(P_EX);
    m_addr = asw;
    hi = 0;
    while (mem_req === 1'b1 && hi < 400) begin
      hi++;
      @(negedge qzt_clk);
    end
    check("to_len", 32'(hi), ACK_TIMEOUT);
    check("to_err", 32'(err), 1);
    check("to_led", 32'(data_led), 32'(m_led));
    check("to_idle", 32'(busy), 0);
    check("to_addr", 32'(mem_addr), 32'(asw));
    $display("txn timeout addr=%h cycles=%0d err=%0d", asw, hi, err);
  endtask

  task automatic run_seq(input logic [6:0] b, input int periods);
    int pulses = 0;
    int en_cycles = 0;
    logic prev = 1'b0;
    logic req_seen = 1'b0;
    press(b);
    check("run_running", 32'(cpu_running), 1);
    check("run_busy", 32'(busy), 1);
    for (int p = 0; p < periods; p++) begin
      int hi = $urandom_range(1, 3);
      int lo = $urandom_range(1, 3);
      cpu_clk_in = 1'b1;
      btn = 7'($urandom_range(0, 31));
      for (int i = 0; i < hi + lo; i++) begin
        @(negedge qzt_clk);
        btn = '0;
        en_cycles += 32'(cpu_clk_en);
        if (cpu_clk_en && !prev) pulses++;
        prev = cpu_clk_en;
        req_seen |= mem_req;
        if (i == hi - 1) cpu_clk_in = 1'b0;
      end
    end
    press(P_STOP | 7'($urandom_range(0, 31)));
    check("stop_running", 32'(cpu_running), 0);
    check("stop_idle", 32'(busy), 0);
    check("run_pulses", 32'(pulses), 32'(periods));
    check("run_pulse_width", 32'(en_cycles), 32'(periods));
    check("run_no_req", 32'(req_seen), 0);
    $display("txn run periods=%0d pulses=%0d", periods, pulses);
  endtask

  task automatic step_seq(input logic [6:0] b);
    int pulses = 0;
    press(b);
    check("step_busy", 32'(busy), 1);
    check("step_en_wait", 32'(cpu_clk_en), 0);
    data_sw = ~m_wdata;
    addr_sw = 16'($urandom);
    press(P_DEP | P_EX);
    check("step_ignore_req", 32'(mem_req), 0);
    check("step_still_busy", 32'(busy), 1);
    repeat ($urandom_range(0, 3)) @(negedge qzt_clk);
    cpu_clk_in = 1'b1;
    repeat (4) begin
      @(negedge qzt_clk);
      pulses += 32'(cpu_clk_en);
    end
    check("step_pulses", 32'(pulses), 1);
    check("step_idle", 32'(busy), 0);
    check("step_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("step_addr", 32'(mem_addr), 32'(m_addr));
    cpu_clk_in = 1'b0;
    @(negedge qzt_clk);
    $display("txn step pulses=%0d", pulses);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge qzt_clk);
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_led", 32'(data_led), 0);
    check("rst_running", 32'(cpu_running), 0);
    check("rst_en", 32'(cpu_clk_en), 0);
    reset = 1'b0;
    @(negedge qzt_clk);

    mem[16'h1234] = 8'hA5;
    mem_txn(P_EX, 16'h1234, 8'h00, 3);
    check("examine_a5", 32'(data_led), 32'h A5);

    mem_txn(P_EX, 16'hFFFF, 8'h00, 1);
    mem_txn(P_DEPN, 16'h0000, 8'h3C, 2);
    check("wrap_addr", 32'(mem_addr), 0);
    check("wrap_led", 32'(data_led), 32'h3C);

    // Stray ack while idle must not touch the display.
    mem_ack = 1'b1;
    mem_rdata = ~m_led;
    @(negedge qzt_clk);
    mem_ack = 1'b0;
    check("stray_ack_led", 32'(data_led), 32'(m_led));
    check("stray_ack_busy", 32'(busy), 0);

    timeout_txn(16'h0BEE);
    mem_txn(P_EX, 16'h0BEE, 8'h00, 0);

    run_seq(P_RUN, 5);

    // Stop coinciding with a CPU clock edge: no tick escapes.
    press(P_RUN);
    cpu_clk_in = 1'b1;
    press(P_STOP);
    check("stop_rise_en", 32'(cpu_clk_en), 0);
    check("stop_rise_running", 32'(cpu_running), 0);
    @(negedge qzt_clk);
    check("stop_rise_en_late", 32'(cpu_clk_en), 0);
    check("stop_rise_idle", 32'(busy), 0);
    cpu_clk_in = 1'b0;
    @(negedge qzt_clk);

    step_seq(P_STEP);

    for (int n = 0; n < 24; n++) begin
      logic [6:0] b;
      logic [15:0] asw;
      int w;
      b = 7'($urandom_range(1, 63));
      asw = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      w = top_cmd(b);
      if (w == 5)      run_seq(b, $urandom_range(1, 3));
      else if (w == 4) step_seq(b);
      else             mem_txn(b, asw, 8'($urandom), $urandom_range(0, 6));
    end

    // Reset while parked in STEP_WAIT with the error flag set.
    timeout_txn(16'($urandom));
    press(P_STEP);
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_err", 32'(err), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_step_busy", 32'(busy), 0);
    check("arst_step_err", 32'(err), 0);
    @(negedge qzt_clk);
    reset = 1'b0;
    @(negedge qzt_clk);

    // Reset while a request is outstanding.
    addr_sw = 16'hBEEF;
    press(P_EX);
    check("pre_rst_req", 32'(mem_req), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_req", 32'(mem_req), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_err", 32'(err), 0);
    check("arst_addr", 32'(mem_addr), 0);
    check("arst_led", 32'(data_led), 0);
    @(negedge qzt_clk);
    reset = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_led = '0;
    @(negedge qzt_clk);
    mem_txn(P_DEP, 16'h5555, 8'h77, 1);
    check("post_rst_addr", 32'(mem_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
